// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one 16-bit saturating add/sub unit.
// Each result is registered one cycle after acceptance and carries the requester id and tag.

module ALU_adder (
  input  logic [15:0] Adder_In1,
  input  logic [15:0] Adder_In2,
  input  logic        sub,
  input  logic        sat,
  output logic [15:0] Adder_Out,
  output logic        Ovfl
);
  logic [15:0] b_eff, sum;

  // Subtraction is A + ~B + 1. Overflow occurs when both addends share a sign and the sum's sign differs.
  assign b_eff = sub ? ~Adder_In2 : Adder_In2;
  assign sum   = Adder_In1 + b_eff + {15'd0, sub};
  assign Ovfl  = (Adder_In1[15] == b_eff[15]) && (sum[15] != Adder_In1[15]);

  always_comb begin
    Adder_Out = sum;
    if (sat && Ovfl) Adder_Out = Adder_In1[15] ? 16'h8000 : 16'h7FFF;
  end
endmodule

module adder_arbiter #(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [15:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req0_sat,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [15:0]      req1_b,
  input  logic             req1_sub,
  input  logic             req1_sat,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_ovfl,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);
  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic             sub;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t [1:0]  req;
  req_t        sel;
  logic        rr_ptr;
  logic        stage_free, gnt_vld, gnt_id, accept;
  logic [15:0] sum;
  logic        ovfl;

  assign req[0] = {req0_a, req0_b, req0_sub, req0_sat, req0_tag};
  assign req[1] = {req1_a, req1_b, req1_sub, req1_sat, req1_tag};

  // A lone requester always wins. rr_ptr only decides the winner when both requesters are valid.
  assign stage_free = ~rsp_valid | rsp_ready;
  assign gnt_vld    = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
  assign accept     = stage_free & gnt_vld;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;
  assign sel        = req[gnt_id];

  ALU_adder u_adder (
    .Adder_In1 (sel.a),
    .Adder_In2 (sel.b),
    .sub       (sel.sub),
    .sat       (sel.sat),
    .Adder_Out (sum),
    .Ovfl      (ovfl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0000;
      rsp_ovfl  <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      rr_ptr    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sum;
      rsp_ovfl  <= ovfl;
      rsp_id    <= gnt_id;
      rsp_tag   <= sel.tag;
      rr_ptr    <= ~gnt_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, arithmetic/saturation, fairness, backpressure, drain.
module tb_adder_arbiter;
  localparam int TAG_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 0, req1_valid = 0;
  logic             req0_ready, req1_ready;
  logic [15:0]      req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic             req0_sub = 0, req0_sat = 0, req1_sub = 0, req1_sat = 0;
  logic [TAG_W-1:0] req0_tag = 0, req1_tag = 0;
  logic             rsp_valid, rsp_ready = 1'b1;
  logic [15:0]      rsp_data;
  logic             rsp_ovfl, rsp_id;
  logic [TAG_W-1:0] rsp_tag;

  int checks = 0;
  int failures = 0;

  adder_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_sat(req0_sat), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_sat(req1_sat), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovfl(rsp_ovfl), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [15:0] d,
                         input logic o, input logic id, input logic [TAG_W-1:0] t);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, "_data"},  {16'd0, rsp_data},  {16'd0, d});
    chk({tag, "_ovfl"},  {31'd0, rsp_ovfl},  {31'd0, o});
    chk({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    chk({tag, "_tag"},   {30'd0, rsp_tag},   {30'd0, t});
  endtask

  // A stalled requester must keep its valid high and its payload stable.
  logic        pend0 = 0, pend1 = 0;
  logic [35:0] hold0, hold1;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend0 = 0;
      pend1 = 0;
    end else begin
      if (pend0) assert (req0_valid && hold0 == {req0_a, req0_b, req0_sub, req0_sat, req0_tag});
      if (pend1) assert (req1_valid && hold1 == {req1_a, req1_b, req1_sub, req1_sat, req1_tag});
      pend0 = req0_valid & ~req0_ready;
      pend1 = req1_valid & ~req1_ready;
      hold0 = {req0_a, req0_b, req0_sub, req0_sat, req0_tag};
      hold1 = {req1_a, req1_b, req1_sub, req1_sat, req1_tag};
    end
  end

  typedef struct {
    logic [15:0] a, b;
    logic        sub, sat;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t sat_vec[4];

  initial begin
    sat_vec[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    sat_vec[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1};
    sat_vec[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1};
    sat_vec[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0};

    // Reset state
    #3;
    chk_rsp("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0);
    #9 rst_n = 1'b1;
    tick();

    // Single add on requester 0
    req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0004; req0_sub = 0; req0_sat = 0; req0_tag = 2'd2;
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0;
    chk_rsp("add", 1'b1, 16'h0007, 1'b0, 1'b0, 2'd2);

    // Saturation and overflow cases on requester 1, back to back
    for (int i = 0; i < 4; i++) begin
      req1_valid = 1; req1_a = sat_vec[i].a; req1_b = sat_vec[i].b;
      req1_sub = sat_vec[i].sub; req1_sat = sat_vec[i].sat; req1_tag = 2'(i);
      #1;
      chk($sformatf("sat%0d_ready1", i), {31'd0, req1_ready}, 32'd1);
      tick();
      chk_rsp($sformatf("sat%0d", i), 1'b1, sat_vec[i].exp_d, sat_vec[i].exp_o, 1'b1, 2'(i));
    end

    // Fairness: both valid, rr_ptr is 0 after requester 1's last grant
    req0_valid = 1; req0_a = 16'd10; req0_b = 16'd1; req0_sub = 0; req0_sat = 0; req0_tag = 2'd1;
    req1_valid = 1; req1_a = 16'd20; req1_b = 16'd2; req1_sub = 0; req1_sat = 0; req1_tag = 2'd2;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) chk_rsp($sformatf("rr%0d", i), 1'b1, 16'd11, 1'b0, 1'b0, 2'd1);
      else            chk_rsp($sformatf("rr%0d", i), 1'b1, 16'd22, 1'b0, 1'b1, 2'd2);
    end

    // Backpressure: hold the requester-1 result for 3 cycles
    rsp_ready = 0;
    #1;
    chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
    chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_rsp($sformatf("bp%0d", i), 1'b1, 16'd22, 1'b0, 1'b1, 2'd2);
      chk($sformatf("bp%0d_rdy", i), {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    rsp_ready = 1;
    #1;
    chk("bp_rel_ready0", {31'd0, req0_ready}, 32'd1);
    chk("bp_rel_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 0;
    chk_rsp("bp_rel", 1'b1, 16'd11, 1'b0, 1'b0, 2'd1);
    #1;
    chk("lone_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    chk_rsp("lone1", 1'b1, 16'd22, 1'b0, 1'b1, 2'd2);

    // Drain with no requests
    tick();
    chk_rsp("drain", 1'b0, 16'd22, 1'b0, 1'b1, 2'd2);

    // Asynchronous reset with a result held under backpressure
    req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1; req0_tag = 2'd3;
    rsp_ready = 0;
    tick();
    req0_valid = 0;
    chk_rsp("pre_rst", 1'b1, 16'd2, 1'b0, 1'b0, 2'd3);
    #1 rst_n = 0;
    #1;
    chk_rsp("async_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0);
    tick();
    rst_n = 1;
    rsp_ready = 1;
    req0_valid = 1; req0_a = 16'd10; req0_b = 16'd1; req0_tag = 2'd1;
    req1_valid = 1;
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    chk_rsp("post_rst0", 1'b1, 16'd11, 1'b0, 1'b0, 2'd1);
    req0_valid = 0;
    tick();
    req1_valid = 0;
    chk_rsp("post_rst1", 1'b1, 16'd22, 1'b0, 1'b1, 2'd2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 16-bit saturating add/sub datapath (instance of ALU_adder) between two requesters, e.g. the execute-stage ALU and an address/branch-target unit.
- Round-robin arbitration, valid/ready handshakes on both request ports, and a one-entry registered response stage with backpressure.
- Result returns one cycle after acceptance, tagged with requester id and a pass-through tag.

Parameters:
- TAG_W, 2, width of the opaque tag carried from request to response.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  16  operand A (Adder_In1)
- req0_b  input  16  operand B (Adder_In2)
- req0_sub  input  1  1 = A-B, 0 = A+B
- req0_sat  input  1  1 = saturate on signed overflow
- req0_tag  input  TAG_W  opaque tag
- req1_valid, req1_ready, req1_a, req1_b, req1_sub, req1_sat, req1_tag  same as requester 0, for requester 1
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  16  result
- rsp_ovfl  output  1  signed overflow occurred
- rsp_id  output  1  requester that issued this result
- rsp_tag  output  TAG_W  tag of the issuing request

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous, active-low.
- Reset values: rsp_valid=0, rsp_data=0x0000, rsp_ovfl=0, rsp_id=0, rsp_tag=0, rr_ptr=0 (requester 0 has priority).
- Stage free: stage_free = !rsp_valid | rsp_ready.
- Grant (combinational):
  - If only one reqN_valid is high, grant goes to N.
  - If both are high, grant goes to rr_ptr.
  - If neither is high, there is no grant.
- Ready: reqN_ready = stage_free & grant==N. At most one ready is high per cycle. Ready may depend on valid.
- Accept: on the clock edge where reqN_valid & reqN_ready:
  - rsp_data <= adder output for requester N's operands;
  - rsp_ovfl <= adder Ovfl;
  - rsp_id <= N, rsp_tag <= reqN_tag, rsp_valid <= 1;
  - rr_ptr <= !N.
- Latency and throughput: latency is 1 cycle (accept at edge T, rsp_valid high after T). Throughput is one result per cycle while rsp_ready=1.
- Drain without refill: rsp_valid & rsp_ready with no accept -> rsp_valid <= 0; rsp_data/ovfl/id/tag hold their last values.
- Simultaneous drain and accept: new result loads and rsp_valid stays 1. There is no bubble.
- Backpressure: while rsp_valid & !rsp_ready, all rsp_* outputs are held stable, both readies are 0, and rr_ptr is unchanged.
- Fairness:
  - With both valid continuously, grants alternate strictly 0,1,0,1.
  - A lone requester is granted every cycle regardless of rr_ptr. rr_ptr still updates to the other requester.
- Arithmetic (16-bit two's complement):
  - Result is A+B, or A-B when sub=1.
  - rsp_ovfl is signed overflow, reported regardless of sat.
  - When sat=1 and overflow: result is 0x7FFF for positive overflow, 0x8000 for negative overflow.
  - Carry-out is not reported.
- Request protocol: while reqN_valid & !reqN_ready, the requester holds its valid high and its operands/tag stable. The bench asserts this. The block does not depend on it for correctness.
- Reset mid-operation: rst_n low clears rsp_valid and rr_ptr immediately (asynchronously). Any in-flight result is discarded. The first cycle after release behaves as post-reset.

Test Plan:
- Reset: drive rst_n=0 mid-run with rsp_valid=1 -> rsp_valid=0, rsp_data=0x0000 without a clock edge. After release, both requesters valid -> first grant goes to 0.
- Single add: req0 a=0x0003, b=0x0004, sub=0, sat=0, tag=2 -> req0_ready=1. Next cycle: rsp_valid=1, rsp_data=0x0007, rsp_ovfl=0, rsp_id=0, rsp_tag=2.
- Saturation on requester 1 (each case -> data, ovfl):
  - a=0x7FFF, b=0x0001, sat=1 -> 0x7FFF, 1
  - same with sat=0 -> 0x8000, 1
  - sub=1, a=0x8000, b=0x0001, sat=1 -> 0x8000, 1
  - sub=1, a=0x0005, b=0x0007 -> 0xFFFE, 0
- Fairness: both valid for 6 cycles with rsp_ready=1 and distinct tags -> rsp_id sequence 0,1,0,1,0,1, one result per cycle, tags matching their issuers.
- Backpressure: rsp_valid=1, rsp_ready=0 for 3 cycles with both requesters valid -> both readies 0, rsp_* stable. Raise rsp_ready -> same-cycle accept of the rr_ptr requester, new result next cycle, no bubble.
- Drain: rsp_ready=1, no valid requests -> rsp_valid falls after one cycle; rsp_data holds its last value.
